// File: rtl/legv8_pkg.sv
// legv8_pkg: shared definitions for the LEGv8 front end.
// Contents: opcode field constants, the HALT encoding, the fetch-unit state
// enum and small classification helpers for the fetch unit.
package legv8_pkg;

    // Branch opcodes are matched on their own field widths: [31:26] and [31:24].
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    // 11-bit [31:21] opcodes seen by the control unit.
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_BR    = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_t;

    function automatic logic is_b(input logic [31:0] word);
        return (word[31:26] == OPC_B);
    endfunction

    function automatic logic is_cbz(input logic [31:0] word);
        return (word[31:24] == OPC_CBZ);
    endfunction

endpackage

// File: rtl/legv8_branch_target.sv
// legv8_branch_target: combinational next-PC candidates for one instruction.
// Ports:
//   pc       in  ADDR_W  PC of the instruction
//   instr    in  32      instruction word
//   tgt_b    out ADDR_W  pc + sext(imm26)<<2
//   tgt_cbz  out ADDR_W  pc + sext(imm19)<<2
//   pc_plus4 out ADDR_W  pc + 4
// All sums wrap modulo 2^ADDR_W. Requires ADDR_W >= 28.
module legv8_branch_target #(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       instr,
    output logic [ADDR_W-1:0] tgt_b,
    output logic [ADDR_W-1:0] tgt_cbz,
    output logic [ADDR_W-1:0] pc_plus4
);

    logic [ADDR_W-1:0] off_b;
    logic [ADDR_W-1:0] off_cbz;
    logic              unused_bits;

    // Sign-extend then append two zeros: identical to (sext << 2) truncated to ADDR_W.
    assign off_b   = {{(ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
    assign off_cbz = {{(ADDR_W-21){instr[23]}}, instr[23:5], 2'b00};

    assign tgt_b    = pc + off_b;
    assign tgt_cbz  = pc + off_cbz;
    assign pc_plus4 = pc + {{(ADDR_W-3){1'b0}}, 3'd4};

    // Opcode and Rt bits play no part in target arithmetic.
    assign unused_bits = ^{instr[31:26], instr[4:0]};

endmodule

// File: rtl/legv8_fetch_unit.sv
// legv8_fetch_unit: instruction fetch/issue stage of the LEGv8 core.
// Holds the PC, fetches one word at a time from instruction memory, hands it
// to decode over valid/ready, and computes the next PC (sequential, B, CBZ).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imem_req/imem_addr         one-cycle fetch request and its address
//   imem_rdata/imem_valid      memory response
//   instr_valid/instr_ready    issue handshake toward decode
//   instr_out/opcode_out/pc_out issued word, its [31:21] field, its PC
//   br_resolve/br_taken        CBZ outcome from execute
//   halted                     HALT word (32'h0) has been issued
module legv8_fetch_unit
    import legv8_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_out,
    output logic [10:0]       opcode_out,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              br_resolve,
    input  logic              br_taken,
    output logic              halted
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tgt_b;
    logic [ADDR_W-1:0] tgt_cbz;
    logic [ADDR_W-1:0] pc_plus4;

    // Targets are always relative to the held instruction's PC.
    legv8_branch_target #(.ADDR_W(ADDR_W)) u_branch_target (
        .pc       (pc_out),
        .instr    (instr_out),
        .tgt_b    (tgt_b),
        .tgt_cbz  (tgt_cbz),
        .pc_plus4 (pc_plus4)
    );

    // Fetch/issue FSM with registered outputs. The request pulse is registered
    // on leaving S_REQ, so it is high during the first S_WAIT cycle; a response
    // can therefore only be taken while waiting, never speculatively.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr_out   <= 32'h0000_0000;
            opcode_out  <= 11'd0;
            pc_out      <= {ADDR_W{1'b0}};
            halted      <= 1'b0;
        end else begin
            imem_req <= 1'b0;
            case (state)
                S_REQ: begin
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        instr_out   <= imem_rdata;
                        opcode_out  <= imem_rdata[31:21];
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (is_b(instr_out)) begin
                            pc    <= tgt_b;
                            state <= S_REQ;
                        end else if (is_cbz(instr_out)) begin
                            state <= S_BR;
                        end else if (instr_out == HALT_WORD) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            pc    <= pc_plus4;
                            state <= S_REQ;
                        end
                    end
                end
                S_BR: begin
                    if (br_resolve) begin
                        pc    <= br_taken ? tgt_cbz : pc_plus4;
                        state <= S_REQ;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    instr_valid <= 1'b0;
                    state       <= S_REQ;
                end
            endcase
        end
    end

endmodule
